psum_gbf_drain: RTL and testbench
=================================

PSUM_GBF_DRAIN -- requirements
Module: psum_gbf_drain

Interface
REQ-001 SHALL have parameter DATA_BITWIDTH, default 512, which is the psum line width.
REQ-002 SHALL have parameter ADDR_BITWIDTH, default 5, which is the line address width.
REQ-003 SHALL have parameter DEPTH, default 32, which is the lines per bank.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low.
REQ-006 w_en  in  1  su_adder psum line write strobe.
REQ-007 w_num  in  1  bank select for write.
REQ-008 w_addr  in  ADDR_BITWIDTH  write line address.
REQ-009 w_data  in  DATA_BITWIDTH  write line data.
REQ-010 r_en / r_num  in  1 / 1  su_adder read strobe and bank select.
REQ-011 r_addr  in  ADDR_BITWIDTH  read line address.
REQ-012 r_data  out  DATA_BITWIDTH  read data, registered.
REQ-013 init_en / init_num  in  1 / 1  zero-initialise strobe and bank select.
REQ-014 init_addr  in  ADDR_BITWIDTH  line to zero.
REQ-015 bank_done  in  1  pulse: bank w_num fully accumulated, hand to drain.
REQ-016 bank_busy  out  2  bit b=1 while bank b is pending or being drained.
REQ-017 out_valid / out_ready  out / in  1 / 1  drain stream handshake.
REQ-018 out_data  out  DATA_BITWIDTH  drained line.
REQ-019 out_bank / out_addr / out_last  out  1 / ADDR_BITWIDTH / 1  source bank, line index, final-line flag.
REQ-020 err  out  1  sticky protocol-violation flag.

Function
REQ-021 SHALL hold two banks of DEPTH x DATA_BITWIDTH; writes and inits take effect at the clock edge.
REQ-022 r_data SHALL equal bank[r_num][r_addr] one cycle after r_en=1; r_data SHALL hold its value when r_en=0.
REQ-023 w_en and init_en targeting the same bank and address in one cycle: the write wins, the init is dropped, and err is set.
REQ-024 Any w_en, r_en or init_en to a bank with bank_busy=1 SHALL be ignored and SHALL set err.
REQ-025 bank_done SHALL set bank_busy[w_num] in the next cycle.
REQ-026 bank_done on an already-busy bank SHALL be ignored and SHALL set err.
REQ-027 The drain FSM SHALL use the states IDLE, FETCH and VALID.
REQ-028 IDLE -> FETCH when any busy bank is undrained. If both banks are pending, the FSM SHALL pick the bank not drained last; after reset it SHALL pick bank 0.
REQ-029 In FETCH, the FSM SHALL read line addr of the selected bank, then go to VALID.
REQ-030 In VALID, out_valid=1, and out_data, out_bank, out_addr and out_last SHALL be stable until out_ready=1.
REQ-031 On a VALID handshake with addr<DEPTH-1, the FSM SHALL increment addr and go to FETCH.
REQ-032 On a VALID handshake with addr=DEPTH-1 (out_last=1), the FSM SHALL clear that bank's bank_busy, wrap addr to 0, and go to IDLE.
REQ-033 Throughput is 1 line per 2 cycles with out_ready held high; first out_valid occurs 2 cycles after bank_busy rises.
REQ-034 Bank contents SHALL remain unchanged by draining; re-zeroing is done only via init.
REQ-035 A bank_done that arrives during a drain of the other bank SHALL be queued; that bank drains immediately after, with no IDLE dwell beyond 1 cycle.

Reset
REQ-036 Assertion (reset=0) SHALL immediately force out_valid=0, out_last=0, out_addr=0, out_bank=0, out_data=0, r_data=0, bank_busy=2'b00, err=0, FSM=IDLE, last-drained=bank 1.
REQ-037 Bank contents are not reset; the su_adder inits lines before use.
REQ-038 A reset during a drain SHALL abandon the drain with no out_last issued.

Structure
REQ-039 A shared package SHALL hold the FSM state encoding and the default width/depth constants, which are common with su_adder.
REQ-040 There SHALL be one sub-module, psum_gbf_bank: a single bank with 1 write port, 1 registered read port, and 1 zero-init port, instantiated twice.
REQ-041 The drain read port and the su_adder read port SHALL be muxed per bank by bank_busy.

Verification
REQ-042 Write bank0 lines 0..31 with value addr+1, pulse bank_done (w_num=0), hold out_ready=1 -> 32 beats: out_data=1..32, out_addr 0..31, out_last only on beat 31, bank_busy[0] drops after beat 31.
REQ-043 Drain bank0 with out_ready toggling 1/0 every cycle -> no beat lost or duplicated; out_data is stable while out_valid=1 and out_ready=0.
REQ-044 Drain bank0 while writing bank1; bank_done on bank1 at beat 10 -> bank1 drains right after bank0, all 64 beats in order, out_bank switches 0->1.
REQ-045 w_en to busy bank0 addr 3 with 0xFF..F -> err=1, and the drained line 3 keeps its original value.
REQ-046 Same-cycle w_en and init_en to bank1 addr 5 with w_data=0xA5 -> line 5 reads 0xA5 one cycle after r_en, err=1.
REQ-047 Assert reset at drain beat 7 -> out_valid=0 immediately, bank_busy=00, next bank_done restarts from out_addr=0.

Source files
------------

// File: rtl/psum_gbf_drain_pkg.sv
// Shared constants and drain FSM encoding for the psum global buffer.
// The su_adder uses the same defaults.
package psum_gbf_drain_pkg;

    localparam int unsigned PSUM_DATA_BITWIDTH = 512;
    localparam int unsigned PSUM_ADDR_BITWIDTH = 5;
    localparam int unsigned PSUM_DEPTH         = 32;
    localparam int unsigned NUM_BANKS          = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } drain_state_e;

endpackage

// File: rtl/psum_gbf_bank.sv
// One psum bank: write port, zero-init port and a registered read port.
// When a write and an init hit the same line in one cycle, the write lands.
module psum_gbf_bank
    import psum_gbf_drain_pkg::*;
#(
    parameter int unsigned DATA_BITWIDTH = PSUM_DATA_BITWIDTH,
    parameter int unsigned ADDR_BITWIDTH = PSUM_ADDR_BITWIDTH,
    parameter int unsigned DEPTH         = PSUM_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w_en,
    input  logic [ADDR_BITWIDTH-1:0] w_addr,
    input  logic [DATA_BITWIDTH-1:0] w_data,
    input  logic                     init_en,
    input  logic [ADDR_BITWIDTH-1:0] init_addr,
    input  logic                     rd_en,
    input  logic [ADDR_BITWIDTH-1:0] rd_addr,
    output logic [DATA_BITWIDTH-1:0] rd_data
);

    logic [DATA_BITWIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; lines are zeroed through init.
    always_ff @(posedge clk) begin
        if (init_en) begin
            mem[init_addr] <= '0;
        end
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/psum_gbf_drain.sv
// Two-bank psum buffer: su_adder accumulates into one bank while a
// completed bank is streamed out line by line over a valid/ready port.
module psum_gbf_drain
    import psum_gbf_drain_pkg::*;
#(
    parameter int unsigned DATA_BITWIDTH = PSUM_DATA_BITWIDTH,
    parameter int unsigned ADDR_BITWIDTH = PSUM_ADDR_BITWIDTH,
    parameter int unsigned DEPTH         = PSUM_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w_en,
    input  logic                     w_num,
    input  logic [ADDR_BITWIDTH-1:0] w_addr,
    input  logic [DATA_BITWIDTH-1:0] w_data,
    input  logic                     r_en,
    input  logic                     r_num,
    input  logic [ADDR_BITWIDTH-1:0] r_addr,
    output logic [DATA_BITWIDTH-1:0] r_data,
    input  logic                     init_en,
    input  logic                     init_num,
    input  logic [ADDR_BITWIDTH-1:0] init_addr,
    input  logic                     bank_done,
    output logic [1:0]               bank_busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_BITWIDTH-1:0] out_data,
    output logic                     out_bank,
    output logic [ADDR_BITWIDTH-1:0] out_addr,
    output logic                     out_last,
    output logic                     err
);

    localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(DEPTH - 1);

    drain_state_e             state_q, state_d;
    logic                     sel_q, sel_d;
    logic                     last_q, last_d;
    logic [ADDR_BITWIDTH-1:0] addr_q, addr_d;
    logic [1:0]               busy_q, busy_d, busy_set, busy_clr;
    logic                     err_q, err_d;
    logic                     drain_rd;

    logic                     conflict, w_ok, init_ok, r_ok, done_ok;
    logic                     r_pend_q, r_sel_q;
    logic [DATA_BITWIDTH-1:0] r_hold_q;

    logic [NUM_BANKS-1:0]     bank_w_en, bank_init_en, bank_rd_en;
    logic [ADDR_BITWIDTH-1:0] bank_rd_addr [NUM_BANKS];
    logic [DATA_BITWIDTH-1:0] bank_rd_data [NUM_BANKS];

    // su_adder port acceptance; any access to a busy bank is dropped and flagged.
    always_comb begin
        conflict = w_en && init_en && (w_num == init_num) && (w_addr == init_addr);
        w_ok     = w_en && !busy_q[w_num];
        init_ok  = init_en && !busy_q[init_num] && !conflict;
        r_ok     = r_en && !busy_q[r_num];
        done_ok  = bank_done && !busy_q[w_num];
        busy_set = done_ok ? (2'b01 << w_num) : 2'b00;
        err_d    = err_q || conflict
                 || (w_en && busy_q[w_num])
                 || (r_en && busy_q[r_num])
                 || (init_en && busy_q[init_num])
                 || (bank_done && busy_q[w_num]);
    end

    // Drain sequencing: pick a pending bank, then fetch/present one line at a time.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        last_d   = last_q;
        drain_rd = 1'b0;
        busy_clr = 2'b00;
        case (state_q)
            IDLE: begin
                if (busy_q != 2'b00) begin
                    state_d = FETCH;
                    sel_d   = (busy_q == 2'b11) ? !last_q : busy_q[1];
                end
            end
            FETCH: begin
                drain_rd = 1'b1;
                state_d  = VALID;
            end
            VALID: begin
                if (out_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        busy_clr[sel_q] = 1'b1;
                        last_d          = sel_q;
                        addr_d          = '0;
                        state_d         = IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_BITWIDTH'(1);
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (busy_q | busy_set) & ~busy_clr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            addr_q   <= '0;
            busy_q   <= 2'b00;
            err_q    <= 1'b0;
            r_pend_q <= 1'b0;
            r_sel_q  <= 1'b0;
            r_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            r_pend_q <= r_ok;
            if (r_ok) begin
                r_sel_q <= r_num;
            end
            r_hold_q <= r_data;
        end
    end

    // Each bank's read port belongs to the drain while busy, else to the su_adder.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        localparam logic BANK_ID = 1'(b);

        assign bank_w_en[b]    = w_ok && (w_num == BANK_ID);
        assign bank_init_en[b] = init_ok && (init_num == BANK_ID);
        assign bank_rd_en[b]   = busy_q[b] ? (drain_rd && (sel_q == BANK_ID))
                                           : (r_en && (r_num == BANK_ID));
        assign bank_rd_addr[b] = busy_q[b] ? addr_q : r_addr;

        psum_gbf_bank #(
            .DATA_BITWIDTH(DATA_BITWIDTH),
            .ADDR_BITWIDTH(ADDR_BITWIDTH),
            .DEPTH        (DEPTH)
        ) u_bank (
            .clk      (clk),
            .reset    (reset),
            .w_en     (bank_w_en[b]),
            .w_addr   (w_addr),
            .w_data   (w_data),
            .init_en  (bank_init_en[b]),
            .init_addr(init_addr),
            .rd_en    (bank_rd_en[b]),
            .rd_addr  (bank_rd_addr[b]),
            .rd_data  (bank_rd_data[b])
        );
    end

    // r_data shows the fresh bank read for one cycle, then a private copy, so a
    // later drain of that bank cannot disturb what the su_adder last read.
    assign r_data    = r_pend_q ? bank_rd_data[r_sel_q] : r_hold_q;

    assign bank_busy = busy_q;
    assign err       = err_q;
    assign out_valid = (state_q == VALID);
    assign out_bank  = sel_q;
    assign out_addr  = addr_q;
    assign out_last  = out_valid && (addr_q == LAST_ADDR);
    assign out_data  = out_valid ? bank_rd_data[sel_q] : '0;

endmodule

// File: tb/tb_psum_gbf_drain.sv
// Randomized bench for psum_gbf_drain against a queue-based model of the
// bank contents, busy flags, error flag and expected drain beat stream.
module tb_psum_gbf_drain;

    localparam int unsigned DW    = 512;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          w_en = 1'b0, w_num = 1'b0;
    logic [AW-1:0] w_addr = '0;
    logic [DW-1:0] w_data = '0;
    logic          r_en = 1'b0, r_num = 1'b0;
    logic [AW-1:0] r_addr = '0;
    logic [DW-1:0] r_data;
    logic          init_en = 1'b0, init_num = 1'b0;
    logic [AW-1:0] init_addr = '0;
    logic          bank_done = 1'b0;
    logic [1:0]    bank_busy;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_bank;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          err;

    psum_gbf_drain dut (
        .clk(clk), .reset(reset),
        .w_en(w_en), .w_num(w_num), .w_addr(w_addr), .w_data(w_data),
        .r_en(r_en), .r_num(r_num), .r_addr(r_addr), .r_data(r_data),
        .init_en(init_en), .init_num(init_num), .init_addr(init_addr),
        .bank_done(bank_done), .bank_busy(bank_busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bank(out_bank), .out_addr(out_addr), .out_last(out_last),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          bank;
        logic [AW-1:0] addr;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] mmem [2][DEPTH];
    logic [1:0]    mbusy = 2'b00;
    logic [1:0]    clr_req = 2'b00;
    logic          merr = 1'b0;
    logic [DW-1:0] mr_data = '0;
    int            n_cmp = 0, n_bad = 0, beats = 0;

    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d;
    logic [AW+1:0] hold_tag;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock of stimulus: advance the model, step the DUT, compare, clear strobes.
    task automatic cyc();
        logic [1:0] set;
        logic       conflict;
        set      = 2'b00;
        conflict = w_en && init_en && (w_num == init_num) && (w_addr == init_addr);
        if (conflict || (w_en && mbusy[w_num]) || (r_en && mbusy[r_num]) ||
            (init_en && mbusy[init_num]) || (bank_done && mbusy[w_num]))
            merr = 1'b1;
        if (r_en && !mbusy[r_num]) mr_data = mmem[r_num][r_addr];
        if (init_en && !mbusy[init_num] && !conflict) mmem[init_num][init_addr] = '0;
        if (w_en && !mbusy[w_num]) mmem[w_num][w_addr] = w_data;
        if (bank_done && !mbusy[w_num]) begin
            set[w_num] = 1'b1;
            for (int a = 0; a < DEPTH; a++)
                exp_q.push_back('{bank: w_num, addr: AW'(a), last: (a == DEPTH - 1),
                                  data: mmem[w_num][a]});
        end
        @(posedge clk);
        mbusy   = (mbusy | set) & ~clr_req;
        clr_req = 2'b00;
        #1;
        check("bank_busy", DW'(bank_busy), DW'(mbusy));
        check("err", DW'(err), DW'(merr));
        check("r_data", r_data, mr_data);
        w_en = 1'b0; init_en = 1'b0; r_en = 1'b0; bank_done = 1'b0;
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_out_valid", DW'(out_valid), '0);
        check("rst_out_last", DW'(out_last), '0);
        check("rst_out_addr", DW'(out_addr), '0);
        check("rst_out_bank", DW'(out_bank), '0);
        check("rst_out_data", out_data, '0);
        check("rst_r_data", r_data, '0);
        check("rst_bank_busy", DW'(bank_busy), '0);
        check("rst_err", DW'(err), '0);
        exp_q.delete();
        mbusy = 2'b00; clr_req = 2'b00; merr = 1'b0; mr_data = '0;
        w_en = 1'b0; init_en = 1'b0; r_en = 1'b0; bank_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high, 1: ready toggles every cycle, 2: random ready
    task automatic wait_drain(input int mode);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mbusy != 2'b00) && n < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            cyc();
            n++;
        end
        check("drain_left", DW'(exp_q.size()), '0);
        out_ready = 1'b1;
    endtask

    task automatic fill_bank(input logic b, input logic use_count);
        for (int a = 0; a < DEPTH; a++) begin
            w_en = 1'b1; w_num = b; w_addr = AW'(a);
            w_data = use_count ? DW'(a + 1) : rand_line();
            cyc();
        end
    endtask

    task automatic pulse_done(input logic b);
        bank_done = 1'b1; w_num = b;
        cyc();
    endtask

    // Drain monitor: handshakes are seen here and happen at the following rising edge.
    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            if (out_valid && hold_v) begin
                check("out_stable_data", out_data, hold_d);
                check("out_stable_tag", DW'({out_bank, out_addr, out_last}), DW'(hold_tag));
            end
            if (out_valid && out_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check("beat_extra", DW'(1), DW'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", out_data, e.data);
                    check("beat_bank", DW'(out_bank), DW'(e.bank));
                    check("beat_addr", DW'(out_addr), DW'(e.addr));
                    check("beat_last", DW'(out_last), DW'(e.last));
                    if (e.last) clr_req[e.bank] = 1'b1;
                end
            end
            hold_v   = out_valid && !out_ready;
            hold_d   = out_data;
            hold_tag = {out_bank, out_addr, out_last};
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, i, n;
        do_reset();

        // zero both banks before use
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++) begin
                init_en = 1'b1; init_num = 1'(b); init_addr = AW'(a);
                cyc();
            end

        // counting pattern, ready held high, latency from busy to first valid
        fill_bank(1'b0, 1'b1);
        pulse_done(1'b0);
        check("busy_rise", DW'(bank_busy), DW'(2'b01));
        cyc();
        check("fetch_no_valid", DW'(out_valid), '0);
        cyc();
        check("first_valid", DW'(out_valid), DW'(1));
        check("first_data", out_data, DW'(1));
        wait_drain(0);

        // random data, ready toggling
        fill_bank(1'b0, 1'b0);
        pulse_done(1'b0);
        wait_drain(1);

        // bank1 filled during bank0 drain, bank1 done queued at beat 10
        fill_bank(1'b0, 1'b0);
        pulse_done(1'b0);
        base = beats; i = 0; n = 0;
        while (beats - base < 10 && n < 200) begin
            if (i < DEPTH) begin
                w_en = 1'b1; w_num = 1'b1; w_addr = AW'(i); w_data = rand_line();
                i++;
            end
            cyc();
            n++;
        end
        pulse_done(1'b1);
        check("both_busy", DW'(bank_busy), DW'(2'b11));
        wait_drain(0);

        // illegal accesses to a busy bank are dropped and flagged
        fill_bank(1'b0, 1'b0);
        out_ready = 1'b0;
        pulse_done(1'b0);
        w_en = 1'b1; w_num = 1'b0; w_addr = AW'(3); w_data = '1;
        cyc();
        check("busy_write_err", DW'(err), DW'(1));
        r_en = 1'b1; r_num = 1'b0; r_addr = AW'(4);
        init_en = 1'b1; init_num = 1'b0; init_addr = AW'(6);
        cyc();
        pulse_done(1'b0);
        wait_drain(2);
        r_en = 1'b1; r_num = 1'b0; r_addr = AW'(3);
        cyc();
        cyc();

        // same-cycle write and init to one line: write wins
        do_reset();
        w_en = 1'b1; w_num = 1'b1; w_addr = AW'(5); w_data = DW'('hA5);
        init_en = 1'b1; init_num = 1'b1; init_addr = AW'(5);
        cyc();
        r_en = 1'b1; r_num = 1'b1; r_addr = AW'(5);
        cyc();
        check("wr_init_data", r_data, DW'('hA5));
        check("wr_init_err", DW'(err), DW'(1));

        // reset in the middle of a drain, then a clean restart
        do_reset();
        fill_bank(1'b0, 1'b0);
        pulse_done(1'b0);
        base = beats; n = 0;
        while (beats - base < 7 && n < 100) begin
            cyc();
            n++;
        end
        check("reached_beat7", DW'(beats - base), DW'(7));
        do_reset();
        pulse_done(1'b0);
        cyc();
        cyc();
        check("restart_addr", DW'(out_addr), '0);
        check("restart_valid", DW'(out_valid), DW'(1));
        wait_drain(0);

        // random traffic on all ports
        for (int c = 0; c < 400; c++) begin
            w_en = ($urandom_range(0, 3) == 0); w_num = 1'($urandom);
            w_addr = AW'($urandom); w_data = rand_line();
            init_en = ($urandom_range(0, 7) == 0); init_num = 1'($urandom);
            init_addr = ($urandom_range(0, 3) == 0) ? w_addr : AW'($urandom);
            r_en = ($urandom_range(0, 2) == 0); r_num = 1'($urandom); r_addr = AW'($urandom);
            bank_done = ($urandom_range(0, 40) == 0);
            out_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        wait_drain(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
